// File: rtl/adder_pkg.sv
// Shared types and constants for the digit-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_pkg;

    // Number of operand bits consumed per RUN cycle.
    localparam int DIGIT_W = 2;

    // Control states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width: ceil(log2(digits)), but never less than one bit.
    function automatic int digitCntWidth(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/two_bit_full_adder.sv
// Purely combinational 2-bit adder with carry in/out; one digit per use.
// Latency: zero cycles (combinational).
// Backpressure: none; holds no state.
module two_bit_full_adder
    import adder_pkg::*;
(
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    input  logic               CarryIn,
    output logic [DIGIT_W-1:0] Sum,
    output logic               CarryOut
);

    // Zero-extend both operands so the top bit of the add is the carry out.
    always_comb begin
        {CarryOut, Sum} = {1'b0, A} + {1'b0, B} + {{DIGIT_W{1'b0}}, CarryIn};
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Adds two WIDTH-bit operands plus carry two bits per cycle, LSB digit first.
// Latency: out_valid rises WIDTH/2 cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Optional: define DIGIT_SERIAL_ADDER_OVF_EN to add the two's-complement Overflow output.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    output logic             Overflow,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W  = digitCntWidth(DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t               state;
    state_t               stateNext;
    logic [WIDTH-1:0]     aReg;
    logic [WIDTH-1:0]     bReg;
    logic                 carryReg;
    logic [CNT_W-1:0]     digitCnt;
    logic                 accept;
    logic                 lastDigit;
    logic [DIGIT_W-1:0]   aDigit;
    logic [DIGIT_W-1:0]   bDigit;
    logic [DIGIT_W-1:0]   digitSum;
    logic                 digitCarry;

    assign accept    = in_valid && in_ready;
    assign lastDigit = (digitCnt == LAST_DIGIT);

    // State register; reset wins over everything, including a half-finished RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: accept -> RUN, last digit -> DONE, consumer handshake -> IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept)    stateNext = RUN;
            RUN:     if (lastDigit) stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready stays low while reset is held.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Select the operand digit addressed by the counter.
    always_comb begin
        aDigit = '0;
        bDigit = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (digitCnt == CNT_W'(d)) begin
                aDigit = aReg[d*DIGIT_W +: DIGIT_W];
                bDigit = bReg[d*DIGIT_W +: DIGIT_W];
            end
        end
    end

    two_bit_full_adder u_digitAdder (
        .A        (aDigit),
        .B        (bDigit),
        .CarryIn  (carryReg),
        .Sum      (digitSum),
        .CarryOut (digitCarry)
    );

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic msbCarryIn;
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign msbCarryIn = aDigit[DIGIT_W-1] ^ bDigit[DIGIT_W-1] ^ digitSum[DIGIT_W-1];
`endif

    // Datapath: capture operands on accept, then write one Sum digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            aReg     <= '0;
            bReg     <= '0;
            carryReg <= 1'b0;
            digitCnt <= '0;
            Sum      <= '0;
            CarryOut <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            Overflow <= 1'b0;
`endif
        end else if (accept) begin
            aReg     <= A;
            bReg     <= B;
            carryReg <= CarryIn;
            digitCnt <= '0;
        end else if (state == RUN) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (digitCnt == CNT_W'(d)) begin
                    Sum[d*DIGIT_W +: DIGIT_W] <= digitSum;
                end
            end
            carryReg <= digitCarry;
            if (lastDigit) begin
                // Counter parks on the last digit; it is cleared by the next accept.
                CarryOut <= digitCarry;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                Overflow <= msbCarryIn ^ digitCarry;
`endif
            end else begin
                digitCnt <= digitCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder at WIDTH=8: directed vector table
// plus hand-written sequences for backpressure, mid-RUN reset and operand changes.
module tb_digit_serial_adder;

    localparam int WIDTH   = 8;
    localparam int LATENCY = WIDTH / 2;
    localparam int TIMEOUT = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CarryIn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Sum;
    logic             CarryOut;
    logic             out_valid;
    logic             out_ready;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             Overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .CarryIn   (CarryIn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .CarryOut  (CarryOut),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        .Overflow  (Overflow),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present operands for one accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int n;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("in_ready_before_issue", int'(in_ready), 1);
        A        = a;
        B        = b;
        CarryIn  = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles after the accepting edge until out_valid (bounded).
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            tick();
            lat++;
        end
    endtask

    // Handshake the result away and confirm in_ready returns one cycle later.
    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_drain", int'(in_ready), 1);
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int lat;
        issue(v.a, v.b, v.cin);
        waitResult(lat);
        check($sformatf("latency[%0d]", idx), lat, LATENCY);
        check($sformatf("sum[%0d]", idx), int'(Sum), int'(v.sum));
        check($sformatf("carry[%0d]", idx), int'(CarryOut), int'(v.cout));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check($sformatf("overflow[%0d]", idx), int'(Overflow), int'(v.ovf));
`endif
        drain();
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1};
        vecs[9] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};

        rst       = 1'b1;
        A         = '0;
        B         = '0;
        CarryIn   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_sum", int'(Sum), 0);
        check("reset_carry", int'(CarryOut), 0);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check("reset_overflow", int'(Overflow), 0);
`endif
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], i);
        end

        // Backpressure: result must hold for three stalled cycles.
        issue(8'h5A, 8'h33, 1'b1);
        waitResult(lat);
        check("bp_latency", lat, LATENCY);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_sum[%0d]", c), int'(Sum), 32'h8E);
            check($sformatf("bp_carry[%0d]", c), int'(CarryOut), 0);
            check($sformatf("bp_valid[%0d]", c), int'(out_valid), 1);
            check($sformatf("bp_in_ready[%0d]", c), int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_same_cycle", int'(in_ready), 0);
        tick();
        out_ready = 1'b0;
        check("bp_in_ready_next_cycle", int'(in_ready), 1);
        check("bp_out_valid_dropped", int'(out_valid), 0);

        // Reset in the second RUN cycle abandons the partial result.
        issue(8'h12, 8'h34, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrun_in_ready", int'(in_ready), 1);
        check("midrun_out_valid", int'(out_valid), 0);
        check("midrun_sum", int'(Sum), 0);
        check("midrun_carry", int'(CarryOut), 0);
        issue(8'h01, 8'h02, 1'b0);
        waitResult(lat);
        check("post_reset_latency", lat, LATENCY);
        check("post_reset_sum", int'(Sum), 32'h03);
        check("post_reset_carry", int'(CarryOut), 0);
        drain();

        // Operand changes after accept must not reach the result.
        issue(8'h10, 8'h20, 1'b0);
        A       = 8'hFF;
        B       = 8'hFF;
        CarryIn = 1'b1;
        waitResult(lat);
        check("change_latency", lat, LATENCY);
        check("change_sum", int'(Sum), 32'h30);
        check("change_carry", int'(CarryOut), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; it must be even and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port A, input, WIDTH bits: operand A.
REQ-005 SHALL have port B, input, WIDTH bits: operand B.
REQ-006 SHALL have port CarryIn, input, 1 bit: initial carry.
REQ-007 SHALL have port in_valid, input, 1 bit: A/B/CarryIn are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 SHALL have port Sum, output, WIDTH bits: result bits.
REQ-010 SHALL have port CarryOut, output, 1 bit: final carry.
REQ-011 SHALL have port out_valid, output, 1 bit: Sum/CarryOut are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE; an accept is in_valid && in_ready at a rising edge.
REQ-015 On accept SHALL register A, B and CarryIn, clear the digit counter and go to RUN.
REQ-016 In RUN SHALL add one 2-bit digit per cycle, LSB digit first:
- digit i = bits [2i+1:2i];
- the carry is registered between digits;
- the 2-bit result is written into the Sum register at digit i.
REQ-017 After the digit counter reaches WIDTH/2-1 SHALL latch CarryOut and go to DONE.
REQ-018 SHALL assert out_valid in DONE, exactly WIDTH/2 cycles after the accepting edge (4 cycles for WIDTH=8).
REQ-019 SHALL hold Sum and CarryOut stable while out_valid=1 && out_ready=0.
REQ-020 On out_valid && out_ready SHALL go to IDLE and raise in_ready on the next cycle; there is no same-cycle accept and re-accept.
REQ-021 SHALL ignore in_valid outside IDLE; operand changes during RUN/DONE have no effect.
REQ-022 SHALL make {CarryOut,Sum} equal A+B+CarryIn modulo 2^(WIDTH+1), covering all inputs, including all-ones + all-ones + 1.
REQ-023 SHALL size the digit counter as $clog2(WIDTH/2) bits, minimum 1, and SHALL NOT wrap while in RUN.

Reset
REQ-024 While rst=1 at a clock edge SHALL, in any state including mid-RUN:
- force the state to IDLE;
- set Sum=0, CarryOut=0, out_valid=0 and the counter to 0;
- abandon any partial result.
REQ-025 SHALL drive in_ready=0 while rst is high, and in_ready=1 from the first edge with rst=0.

Configuration
REQ-026 With macro DIGIT_SERIAL_ADDER_OVF_EN defined, SHALL add output Overflow, 1 bit:
- Overflow = the carry into the MSB XOR the carry out of the MSB (two's-complement overflow);
- it is latched with CarryOut;
- it is 0 on reset;
- it is valid with out_valid.
REQ-027 Without DIGIT_SERIAL_ADDER_OVF_EN, the Overflow port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package adder_pkg SHALL hold:
- the FSM state enum typedef (IDLE, RUN, DONE);
- the digit width constant DIGIT_W=2.
REQ-029 The per-digit addition SHALL be a combinational sub-module two_bit_full_adder, with ports A[1:0], B[1:0], CarryIn, Sum[1:0] and CarryOut, instantiated once.
REQ-030 SHALL keep all registers in the top module; the sub-module holds no state.

Verification (WIDTH=8)
REQ-031 The bench SHALL drive A=0xFF, B=0x01, CarryIn=0 -> Sum=0x00, CarryOut=1, out_valid 4 cycles after accept.
REQ-032 The bench SHALL drive A=0xFF, B=0xFF, CarryIn=1 -> Sum=0xFF, CarryOut=1; with OVF_EN, Overflow=0.
REQ-033 The bench SHALL drive A=0x7F, B=0x01, CarryIn=0 with OVF_EN -> Sum=0x80, CarryOut=0, Overflow=1.
REQ-034 The bench SHALL drive A=0x5A, B=0x33, CarryIn=1 with out_ready held 0 for 3 cycles:
- Sum=0x8E and CarryOut=0 stay stable;
- in_ready=0 until 1 cycle after out_ready=1.
REQ-035 The bench SHALL assert rst for 1 cycle at the 2nd RUN cycle of A=0x12, B=0x34 -> the next cycle shows IDLE, in_ready=1, out_valid=0 and Sum=0x00; a new A=0x01, B=0x02 then gives Sum=0x03.
REQ-036 The bench SHALL change A/B in the cycle after accepting A=0x10, B=0x20 -> the result is Sum=0x30, unaffected by the change.
